// File: rtl/connection_block_sc_pkg.sv
// cb_pkg: shared types and sizing helpers for connection_block_sc.
//   cb_state_e       configuration state machine encoding
//   cb_sel_out()     width of one track output-mux select
//   cb_sel_in()      width of one CLB input-mux select
//   cb_conf_width()  total configuration bits (shadow/active width)
//   cb_track_driver() which output mux (if any) owns a given track index
package cb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2,
    ERR   = 2'd3
  } cb_state_e;

  function automatic int cb_sel_out(input int clbout);
    return $clog2(2 * clbout + 1);
  endfunction

  function automatic int cb_sel_in(input int ws, input int wd, input int wg,
                                   input int clbx, input int clbout);
    return $clog2((ws + wd) * 2 + wg + clbx * clbout);
  endfunction

  function automatic int cb_conf_width(input int sel_out, input int sel_in,
                                       input int clbos, input int clbod,
                                       input int clbin);
    return 2 * sel_out * (clbos + clbod) + 2 * sel_in * clbin;
  endfunction

  // Returns the output-mux index that lands on track t after rotation, or -1
  // when the track is not CLB-drivable. The last matching mux wins.
  function automatic int cb_track_driver(input int t, input int n_mux,
                                         input int rot, input int n_trk);
    int r;
    r = -1;
    for (int i = 0; i < n_mux; i++) begin
      if (((i + rot) % n_trk) == t) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/connection_block_sc_muxn.sv
// muxn: parametrised N:1 single-bit multiplexer.
//   i_data [N-1:0]  candidate inputs, index 0 first
//   i_sel  [SW-1:0] select; values >= N give 0
//   o_y             selected bit
// SW must satisfy 2**SW >= N.
module muxn #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  i_data,
  input  logic [SW-1:0] i_sel,
  output logic          o_y
);

  localparam int PW = 1 << SW;

  // Zero-padding to the full select range makes out-of-range selects read 0.
  logic [PW-1:0] w_pad;

  assign w_pad = PW'(i_data);
  assign o_y   = w_pad[i_sel];

endmodule

// File: rtl/connection_block_sc.sv
// connection_block_sc: serially configured connection block between two CLBs
// and a unidirectional routing channel.
//   i_clk / i_rst_n             clock, asynchronous active-low reset
//   i_cfg_in/en/load/clear      bit-serial config chain and control
//   i_cfg_capture               (CB_CFG_READBACK_EN only) active -> shadow
//   o_cfg_out                   chain output (shadow MSB)
//   o_cfg_done / o_cfg_err      commit pulse / sticky short-load error
//   i_single*/o_single*         single tracks, both directions
//   i_double*/o_double*         double tracks, both directions
//   i_global                    global lines
//   i_clb*_output/o_clb*_input  CLB outputs / CLB input selections
//   i_clb*_cout/o_clb*_cin      direct carry crossover
// Optional feature macro: CB_CFG_READBACK_EN.
//
// state | meaning
// IDLE  | bit count 0, waiting for the first shift
// SHIFT | counting shifted bits towards CONF_WIDTH
// ARMED | full frame in shadow, cfg_load commits
// ERR   | load arrived early; counter frozen until cfg_clear
module connection_block_sc
  import cb_pkg::*;
#(
  parameter int WS         = 8,
  parameter int WD         = 8,
  parameter int WG         = 3,
  parameter int CLBIN      = 6,
  parameter int CLBOUT     = 1,
  parameter int CARRY      = 1,
  parameter int CLBOS      = 2,
  parameter int CLBOS_BIAS = 0,
  parameter int CLBOD      = 2,
  parameter int CLBOD_BIAS = 0,
  parameter int CLBX       = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_in,
  input  logic              i_cfg_en,
  input  logic              i_cfg_load,
  input  logic              i_cfg_clear,
`ifdef CB_CFG_READBACK_EN
  input  logic              i_cfg_capture,
`endif
  output logic              o_cfg_out,
  output logic              o_cfg_done,
  output logic              o_cfg_err,
  input  logic [WS-1:0]     i_single0_in,
  input  logic [WS-1:0]     i_single1_in,
  output logic [WS-1:0]     o_single0_out,
  output logic [WS-1:0]     o_single1_out,
  input  logic [WD-1:0]     i_double0_in,
  input  logic [WD-1:0]     i_double1_in,
  output logic [WD-1:0]     o_double0_out,
  output logic [WD-1:0]     o_double1_out,
  input  logic [WG-1:0]     i_global,
  input  logic [CLBOUT-1:0] i_clb0_output,
  input  logic [CLBOUT-1:0] i_clb1_output,
  input  logic [CARRY-1:0]  i_clb0_cout,
  input  logic [CARRY-1:0]  i_clb1_cout,
  output logic [CLBIN-1:0]  o_clb0_input,
  output logic [CLBIN-1:0]  o_clb1_input,
  output logic [CARRY-1:0]  o_clb0_cin,
  output logic [CARRY-1:0]  o_clb1_cin
);

  localparam int SEL_OUT    = cb_sel_out(CLBOUT);
  localparam int SEL_IN     = cb_sel_in(WS, WD, WG, CLBX, CLBOUT);
  localparam int CONF_WIDTH = cb_conf_width(SEL_OUT, SEL_IN, CLBOS, CLBOD, CLBIN);
  localparam int CNT_W      = $clog2(CONF_WIDTH + 1);
  localparam int N_OUT      = 2 * CLBOUT + 1;
  localparam int N_IN       = (WS + WD) * 2 + WG + CLBX * CLBOUT;
  localparam int WDH        = WD / 2;
  localparam int S_ROT      = (CLBOS_BIAS * CLBOS) % WS;
  localparam int D_ROT      = (CLBOD_BIAS * CLBOD) % WDH;
  localparam int D_BASE     = 2 * CLBOS * SEL_OUT;
  localparam int I0_BASE    = D_BASE + 2 * CLBOD * SEL_OUT;
  localparam int I1_BASE    = I0_BASE + CLBIN * SEL_IN;

  // ---------------------------------------------------------------- config
  cb_state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CONF_WIDTH-1:0]  r_shadow, w_shadow_nxt;
  logic [CONF_WIDTH-1:0]  r_active, w_active_nxt;
  logic                   r_done, w_done_nxt;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_active <= w_active_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Priority: clear > capture > load > shift. A load or clear cycle never
  // shifts, so the chain and the bit count stay in step.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_active_nxt = r_active;
    w_done_nxt   = 1'b0;
    if (i_cfg_clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
`ifdef CB_CFG_READBACK_EN
    else if (i_cfg_capture && (r_state == IDLE || r_state == ARMED)) begin
      w_shadow_nxt = r_active;
      w_cnt_nxt    = CNT_W'(CONF_WIDTH);
      w_state_nxt  = ARMED;
    end
`endif
    else if (i_cfg_load) begin
      case (r_state)
        ARMED: begin
          w_active_nxt = r_shadow;
          w_done_nxt   = 1'b1;
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
        end
        ERR:     ;
        default: w_state_nxt = ERR;
      endcase
    end else if (i_cfg_en) begin
      w_shadow_nxt = {r_shadow[CONF_WIDTH-2:0], i_cfg_in};
      case (r_state)
        IDLE, SHIFT: begin
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = (w_cnt_inc == CNT_W'(CONF_WIDTH)) ? ARMED : SHIFT;
        end
        default: ;
      endcase
    end
  end

  assign o_cfg_out  = r_shadow[CONF_WIDTH-1];
  assign o_cfg_done = r_done;
  assign o_cfg_err  = (r_state == ERR);

  // ------------------------------------------------------ track output muxes
  // m0 feeds the track continuing direction 0 (single1_out), m1 the other.
  logic [CLBOS-1:0] w_s_drv0, w_s_drv1;
  logic [CLBOD-1:0] w_d_drv0, w_d_drv1;

  for (genvar gi = 0; gi < CLBOS; gi++) begin : g_smux
    localparam int K = (gi + S_ROT) % WS;
    logic [SEL_OUT-1:0] w_sel0, w_sel1;
    logic               w_m0, w_m1;
    assign w_sel0 = r_active[(2*gi)*SEL_OUT +: SEL_OUT];
    assign w_sel1 = r_active[(2*gi+1)*SEL_OUT +: SEL_OUT];
    muxn #(.N(N_OUT), .SW(SEL_OUT)) u_m0 (
      .i_data({i_clb1_output, i_clb0_output, i_single0_in[K]}),
      .i_sel (w_sel0),
      .o_y   (w_m0)
    );
    muxn #(.N(N_OUT), .SW(SEL_OUT)) u_m1 (
      .i_data({i_clb1_output, i_clb0_output, i_single1_in[K]}),
      .i_sel (w_sel1),
      .o_y   (w_m1)
    );
    assign w_s_drv0[gi] = (int'(w_sel0) < N_OUT) ? w_m0 : i_single0_in[K];
    assign w_s_drv1[gi] = (int'(w_sel1) < N_OUT) ? w_m1 : i_single1_in[K];
  end

  for (genvar gi = 0; gi < CLBOD; gi++) begin : g_dmux
    localparam int K = (gi + D_ROT) % WDH;
    logic [SEL_OUT-1:0] w_sel0, w_sel1;
    logic               w_m0, w_m1;
    assign w_sel0 = r_active[D_BASE + (2*gi)*SEL_OUT +: SEL_OUT];
    assign w_sel1 = r_active[D_BASE + (2*gi+1)*SEL_OUT +: SEL_OUT];
    muxn #(.N(N_OUT), .SW(SEL_OUT)) u_m0 (
      .i_data({i_clb1_output, i_clb0_output, i_double0_in[K]}),
      .i_sel (w_sel0),
      .o_y   (w_m0)
    );
    muxn #(.N(N_OUT), .SW(SEL_OUT)) u_m1 (
      .i_data({i_clb1_output, i_clb0_output, i_double1_in[K]}),
      .i_sel (w_sel1),
      .o_y   (w_m1)
    );
    assign w_d_drv0[gi] = (int'(w_sel0) < N_OUT) ? w_m0 : i_double0_in[K];
    assign w_d_drv1[gi] = (int'(w_sel1) < N_OUT) ? w_m1 : i_double1_in[K];
  end

  // Undriven tracks pass straight through with the direction swap.
  for (genvar gt = 0; gt < WS; gt++) begin : g_strk
    localparam int DI = cb_track_driver(gt, CLBOS, S_ROT, WS);
    if (DI >= 0) begin : g_drv
      assign o_single1_out[gt] = w_s_drv0[DI];
      assign o_single0_out[gt] = w_s_drv1[DI];
    end else begin : g_pass
      assign o_single1_out[gt] = i_single0_in[gt];
      assign o_single0_out[gt] = i_single1_in[gt];
    end
  end

  for (genvar gt = 0; gt < WD; gt++) begin : g_dtrk
    localparam int DI = cb_track_driver(gt, CLBOD, D_ROT, WDH);
    if (DI >= 0) begin : g_drv
      assign o_double1_out[gt] = w_d_drv0[DI];
      assign o_double0_out[gt] = w_d_drv1[DI];
    end else begin : g_pass
      assign o_double1_out[gt] = i_double0_in[gt];
      assign o_double0_out[gt] = i_double1_in[gt];
    end
  end

  // -------------------------------------------------------- CLB input muxes
  logic [N_IN-1:0] w_in_vec0, w_in_vec1;

  if (CLBX != 0) begin : g_x
    assign w_in_vec0 = {i_clb1_output, i_global, i_double1_in, i_double0_in,
                        i_single1_in, i_single0_in};
    assign w_in_vec1 = {i_clb0_output, i_global, i_double1_in, i_double0_in,
                        i_single1_in, i_single0_in};
  end else begin : g_nox
    assign w_in_vec0 = {i_global, i_double1_in, i_double0_in, i_single1_in, i_single0_in};
    assign w_in_vec1 = w_in_vec0;
  end

  for (genvar gj = 0; gj < CLBIN; gj++) begin : g_imux
    muxn #(.N(N_IN), .SW(SEL_IN)) u_c0 (
      .i_data(w_in_vec0),
      .i_sel (r_active[I0_BASE + gj*SEL_IN +: SEL_IN]),
      .o_y   (o_clb0_input[gj])
    );
    muxn #(.N(N_IN), .SW(SEL_IN)) u_c1 (
      .i_data(w_in_vec1),
      .i_sel (r_active[I1_BASE + gj*SEL_IN +: SEL_IN]),
      .o_y   (o_clb1_input[gj])
    );
  end

  assign o_clb1_cin = i_clb0_cout;
  assign o_clb0_cin = i_clb1_cout;

endmodule

// File: tb/tb_connection_block_sc.sv
module tb_connection_block_sc;

  logic clk = 1'b0;
  logic rst_n, cfg_in, cfg_en, cfg_load, cfg_clear;
`ifdef CB_CFG_READBACK_EN
  logic cfg_capture;
`endif
  logic [1:0] s0_in, s1_in, d0_in, d1_in;
  logic [0:0] glb, c0_o, c1_o, c0_co, c1_co;

  logic       a_cfg_out, a_done, a_err;
  logic [1:0] a_s0o, a_s1o, a_d0o, a_d1o, a_c0i, a_c1i;
  logic [0:0] a_c0cin, a_c1cin;
  logic       b_cfg_out, b_done, b_err;
  logic [1:0] b_s0o, b_s1o, b_d0o, b_d1o, b_c0i, b_c1i;
  logic [0:0] b_c0cin, b_c1cin;

  int n_cmp = 0;
  int n_bad = 0;
  logic sb[$];
  logic [23:0] cfg_a, cfg_b, cfg_c, cfg_d, cfg_e, cfg_f;

  always #5 clk = ~clk;

  connection_block_sc #(
    .WS(2), .WD(2), .WG(1), .CLBIN(2), .CLBOUT(1), .CARRY(1),
    .CLBOS(1), .CLBOS_BIAS(0), .CLBOD(1), .CLBOD_BIAS(0), .CLBX(1)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_in(cfg_in), .i_cfg_en(cfg_en),
    .i_cfg_load(cfg_load), .i_cfg_clear(cfg_clear),
`ifdef CB_CFG_READBACK_EN
    .i_cfg_capture(cfg_capture),
`endif
    .o_cfg_out(a_cfg_out), .o_cfg_done(a_done), .o_cfg_err(a_err),
    .i_single0_in(s0_in), .i_single1_in(s1_in),
    .o_single0_out(a_s0o), .o_single1_out(a_s1o),
    .i_double0_in(d0_in), .i_double1_in(d1_in),
    .o_double0_out(a_d0o), .o_double1_out(a_d1o),
    .i_global(glb), .i_clb0_output(c0_o), .i_clb1_output(c1_o),
    .i_clb0_cout(c0_co), .i_clb1_cout(c1_co),
    .o_clb0_input(a_c0i), .o_clb1_input(a_c1i),
    .o_clb0_cin(a_c0cin), .o_clb1_cin(a_c1cin)
  );

  connection_block_sc #(
    .WS(2), .WD(2), .WG(1), .CLBIN(2), .CLBOUT(1), .CARRY(1),
    .CLBOS(1), .CLBOS_BIAS(0), .CLBOD(1), .CLBOD_BIAS(0), .CLBX(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_in(a_cfg_out), .i_cfg_en(cfg_en),
    .i_cfg_load(cfg_load), .i_cfg_clear(cfg_clear),
`ifdef CB_CFG_READBACK_EN
    .i_cfg_capture(cfg_capture),
`endif
    .o_cfg_out(b_cfg_out), .o_cfg_done(b_done), .o_cfg_err(b_err),
    .i_single0_in(s0_in), .i_single1_in(s1_in),
    .o_single0_out(b_s0o), .o_single1_out(b_s1o),
    .i_double0_in(d0_in), .i_double1_in(d1_in),
    .o_double0_out(b_d0o), .o_double1_out(b_d1o),
    .i_global(glb), .i_clb0_output(c0_o), .i_clb1_output(c1_o),
    .i_clb0_cout(c0_co), .i_clb1_cout(c1_co),
    .o_clb0_input(b_c0i), .o_clb1_input(b_c1i),
    .o_clb0_cin(b_c0cin), .o_clb1_cin(b_c1cin)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {c1 in1, c1 in0, c0 in1, c0 in0, double m1, double m0, single m1, single m0}
  function automatic logic [23:0] mk_cfg(input logic [1:0] sm0, input logic [1:0] sm1,
                                         input logic [1:0] dm0, input logic [1:0] dm1,
                                         input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] b0, input logic [3:0] b1);
    return {b1, b0, a1, a0, dm1, dm0, sm1, sm0};
  endfunction

  function automatic logic o_sel(input logic [1:0] sel, input logic pass,
                                 input logic x0, input logic x1);
    case (sel)
      2'd1:    return x0;
      2'd2:    return x1;
      default: return pass;
    endcase
  endfunction

  function automatic logic in_sel(input logic [3:0] sel, input logic [9:0] vec);
    return (sel < 4'd10) ? vec[sel] : 1'b0;
  endfunction

  task automatic check_route(input string tag, input logic [23:0] cfg, input bit which);
    logic [9:0] v0, v1;
    logic [1:0] e_s0o, e_s1o, e_d0o, e_d1o, e_c0i, e_c1i;
    for (int p = 0; p < 3; p++) begin
      {s0_in, s1_in, d0_in, d1_in} = 8'($urandom);
      {glb, c0_o, c1_o, c0_co, c1_co} = 5'($urandom);
      #1;
      v0 = {c1_o, glb, d1_in, d0_in, s1_in, s0_in};
      v1 = {c0_o, glb, d1_in, d0_in, s1_in, s0_in};
      e_s1o = {s0_in[1], o_sel(cfg[1:0], s0_in[0], c0_o[0], c1_o[0])};
      e_s0o = {s1_in[1], o_sel(cfg[3:2], s1_in[0], c0_o[0], c1_o[0])};
      e_d1o = {d0_in[1], o_sel(cfg[5:4], d0_in[0], c0_o[0], c1_o[0])};
      e_d0o = {d1_in[1], o_sel(cfg[7:6], d1_in[0], c0_o[0], c1_o[0])};
      e_c0i = {in_sel(cfg[15:12], v0), in_sel(cfg[11:8], v0)};
      e_c1i = {in_sel(cfg[23:20], v1), in_sel(cfg[19:16], v1)};
      check_val({tag, ".s0out"}, 32'(which ? b_s0o : a_s0o), 32'(e_s0o));
      check_val({tag, ".s1out"}, 32'(which ? b_s1o : a_s1o), 32'(e_s1o));
      check_val({tag, ".d0out"}, 32'(which ? b_d0o : a_d0o), 32'(e_d0o));
      check_val({tag, ".d1out"}, 32'(which ? b_d1o : a_d1o), 32'(e_d1o));
      check_val({tag, ".clb0in"}, 32'(which ? b_c0i : a_c0i), 32'(e_c0i));
      check_val({tag, ".clb1in"}, 32'(which ? b_c1i : a_c1i), 32'(e_c1i));
      check_val({tag, ".cin"}, 32'(which ? {b_c0cin, b_c1cin} : {a_c0cin, a_c1cin}),
                32'({c1_co, c0_co}));
    end
  endtask

  // One shift; cfg_out of the first block must show the bit shifted 24 shifts ago.
  task automatic shift_bit(input logic b);
    cfg_in = b;
    cfg_en = 1'b1;
    @(posedge clk);
    #1;
    cfg_en = 1'b0;
    sb.push_back(b);
    if (sb.size() == 24) check_val("cfg_out_lag", 32'(a_cfg_out), 32'(sb.pop_front()));
  endtask

  task automatic shift_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) shift_bit(w[i]);
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    cfg_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_in = 1'b0; cfg_en = 1'b0; cfg_load = 1'b0; cfg_clear = 1'b0;
`ifdef CB_CFG_READBACK_EN
    cfg_capture = 1'b0;
`endif
    s0_in = '0; s1_in = '0; d0_in = '0; d1_in = '0;
    glb = '0; c0_o = '0; c1_o = '0; c0_co = '0; c1_co = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.cfg_out", 32'(a_cfg_out), 0);
    check_val("rst.done", 32'(a_done), 0);
    check_val("rst.err", 32'(a_err), 0);
    check_route("rst", 24'h0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full load
    cfg_a = mk_cfg(2'd1, 2'd2, 2'd0, 2'd2, 4'd9, 4'd8, 4'd5, 4'd3);
    shift_bits(cfg_a, 24);
    check_val("armed.done", 32'(a_done), 0);
    check_val("armed.err", 32'(a_err), 0);
    check_route("pre_load", 24'h0, 1'b0);
    pulse_load();
    check_val("load_a.done", 32'(a_done), 1);
    check_route("load_a", cfg_a, 1'b0);
    @(posedge clk);
    #1;
    check_val("load_a.done_low", 32'(a_done), 0);

    // short load, sticky error, clear
    cfg_b = mk_cfg(2'd2, 2'd1, 2'd1, 2'd0, 4'd0, 4'd7, 4'd9, 4'd4);
    shift_bits(cfg_b, 23);
    pulse_load();
    check_val("short.err", 32'(a_err), 1);
    check_val("short.done", 32'(a_done), 0);
    check_route("short_keep", cfg_a, 1'b0);
    shift_bits(cfg_b, 3);
    pulse_load();
    check_val("err_sticky", 32'(a_err), 1);
    check_val("err_nodone", 32'(a_done), 0);
    pulse_clear();
    check_val("clear.err", 32'(a_err), 0);
    shift_bits(cfg_b, 23);
    pulse_load();
    check_val("clear_cnt0.err", 32'(a_err), 1);
    pulse_clear();
    shift_bits(cfg_b, 24);
    pulse_load();
    check_val("load_b.done", 32'(a_done), 1);
    check_route("load_b", cfg_b, 1'b0);

    // load beats shift, out-of-range selects
    cfg_c = mk_cfg(2'd3, 2'd0, 2'd2, 2'd3, 4'd12, 4'd1, 4'd9, 4'd10);
    shift_bits(cfg_c, 24);
    cfg_in = 1'b1; cfg_en = 1'b1; cfg_load = 1'b1;
    @(posedge clk);
    #1;
    cfg_en = 1'b0; cfg_load = 1'b0;
    check_val("prio.done", 32'(a_done), 1);
    check_val("prio.no_shift", 32'(a_cfg_out), 32'(cfg_c[23]));
    check_route("prio", cfg_c, 1'b0);

    // clear beats load and shift
    cfg_d = mk_cfg(2'd2, 2'd2, 2'd1, 2'd1, 4'd2, 4'd3, 4'd4, 4'd6);
    shift_bits(cfg_d, 24);
    cfg_in = 1'b1; cfg_en = 1'b1; cfg_load = 1'b1; cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    cfg_en = 1'b0; cfg_load = 1'b0; cfg_clear = 1'b0;
    check_val("clrprio.done", 32'(a_done), 0);
    check_val("clrprio.err", 32'(a_err), 0);
    check_val("clrprio.no_shift", 32'(a_cfg_out), 32'(cfg_d[23]));
    check_route("clrprio", cfg_c, 1'b0);
    pulse_load();
    check_val("clrprio.idle", 32'(a_err), 1);
    pulse_clear();

    // two-block chain
    cfg_e = mk_cfg(2'd2, 2'd1, 2'd2, 2'd1, 4'd9, 4'd4, 4'd9, 4'd1);
    cfg_f = mk_cfg(2'd1, 2'd1, 2'd1, 2'd2, 4'd6, 4'd9, 4'd8, 4'd9);
    shift_bits(cfg_e, 24);
    shift_bits(cfg_f, 24);
    pulse_load();
    check_val("chain.done0", 32'(a_done), 1);
    check_val("chain.done1", 32'(b_done), 1);
    check_route("chain0", cfg_f, 1'b0);
    check_route("chain1", cfg_e, 1'b1);

`ifdef CB_CFG_READBACK_EN
    cfg_capture = 1'b1;
    @(posedge clk);
    #1;
    cfg_capture = 1'b0;
    sb.delete();
    for (int i = 23; i >= 0; i--) begin
      check_val("readback", 32'(a_cfg_out), 32'(cfg_f[i]));
      shift_bit(cfg_f[i]);
    end
    pulse_load();
    check_val("readback.done", 32'(a_done), 1);
    check_route("readback", cfg_f, 1'b0);
`endif

    // asynchronous reset in the middle of a shift sequence
    shift_bits(cfg_e, 10);
    rst_n = 1'b0;
    #1;
    check_val("rstmid.cfg_out", 32'(a_cfg_out), 0);
    check_val("rstmid.done", 32'(a_done), 0);
    check_val("rstmid.err", 32'(a_err), 0);
    check_route("rstmid", 24'h0, 1'b0);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
